// File: rtl/tape_motion_ctl.sv
// Paper-tape reader motion controller: arbitrates forward/reverse/rewind requests
// and sequences relay pull-in, motor drive and stop dead time.
module tape_motion_ctl #(
    parameter int unsigned PULLIN_MS     = 5,
    parameter int unsigned DEAD_MS       = 10,
    parameter int unsigned REWIND_MAX_MS = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_ms,
    input  logic       cmd_fwd,
    input  logic       cmd_rev,
    input  logic       remote_rewind,
    input  logic       sw1_rewind,
    input  logic       sw1_forward,
    input  logic       sw2,
    output logic       motor_fwd,
    output logic       motor_rev,
    output logic       wait_for_tape,
    output logic [1:0] owner,
    output logic       rewind_timeout,
    output logic       conflict
);

    localparam logic [15:0] PULLIN_LAST = 16'(PULLIN_MS - 1);
    localparam logic [15:0] DEAD_LAST   = 16'(DEAD_MS - 1);
    localparam logic [15:0] REWIND_LAST = 16'(REWIND_MAX_MS - 1);

    localparam logic [1:0] OWN_NONE   = 2'd0;
    localparam logic [1:0] OWN_CMD    = 2'd1;
    localparam logic [1:0] OWN_PANEL  = 2'd2;
    localparam logic [1:0] OWN_REWIND = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        PULL_FWD,
        RUN_FWD,
        PULL_REV,
        RUN_REV,
        DEAD
    } state_t;

    state_t      state, state_nx;
    logic [15:0] cnt, cnt_nx, cnt_inc;
    logic [1:0]  owner_nx;
    logic        timeout_set;

    logic       rewind_req, comp_req;
    logic       win_vld, win_rev;
    logic [1:0] win_owner;

    // Fixed-priority arbitration; a latched timeout suppresses only the rewind sources.
    always_comb begin
        rewind_req = (remote_rewind | sw1_rewind) & ~rewind_timeout;
        comp_req   = cmd_fwd ^ cmd_rev;
        win_vld    = 1'b0;
        win_rev    = 1'b0;
        win_owner  = OWN_NONE;
        if (sw2) begin
            if (rewind_req) begin
                win_vld   = 1'b1;
                win_rev   = 1'b1;
                win_owner = OWN_REWIND;
            end else if (sw1_forward) begin
                win_vld   = 1'b1;
                win_owner = OWN_PANEL;
            end else if (comp_req) begin
                win_vld   = 1'b1;
                win_rev   = cmd_rev;
                win_owner = OWN_CMD;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        owner_nx    = owner;
        timeout_set = 1'b0;
        cnt_inc     = cnt + 16'(tick_ms);
        case (state)
            IDLE: begin
                if (win_vld) begin
                    state_nx = win_rev ? PULL_REV : PULL_FWD;
                    owner_nx = win_owner;
                    cnt_nx   = '0;
                end
            end
            PULL_FWD, PULL_REV: begin
                if (!win_vld || (win_rev != (state == PULL_REV))) begin
                    state_nx = DEAD;
                    owner_nx = OWN_NONE;
                    cnt_nx   = '0;
                end else begin
                    owner_nx = win_owner;
                    if (tick_ms && cnt == PULLIN_LAST) begin
                        state_nx = (state == PULL_REV) ? RUN_REV : RUN_FWD;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
            end
            RUN_FWD: begin
                if (!win_vld || win_rev) begin
                    state_nx = DEAD;
                    owner_nx = OWN_NONE;
                    cnt_nx   = '0;
                end else begin
                    owner_nx = win_owner;
                end
            end
            RUN_REV: begin
                if (!win_vld || !win_rev) begin
                    state_nx = DEAD;
                    owner_nx = OWN_NONE;
                    cnt_nx   = '0;
                end else if (owner == OWN_REWIND && tick_ms && cnt == REWIND_LAST) begin
                    state_nx    = DEAD;
                    owner_nx    = OWN_NONE;
                    cnt_nx      = '0;
                    timeout_set = 1'b1;
                end else begin
                    owner_nx = win_owner;
                    // Only a rewind run is time-limited; computer reverse runs freely.
                    if (owner == OWN_REWIND) begin
                        cnt_nx = cnt_inc;
                    end
                end
            end
            DEAD: begin
                owner_nx = OWN_NONE;
                if (tick_ms && cnt == DEAD_LAST) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt_inc;
                end
            end
            default: begin
                state_nx = IDLE;
                owner_nx = OWN_NONE;
                cnt_nx   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            owner          <= OWN_NONE;
            rewind_timeout <= 1'b0;
            conflict       <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            owner    <= owner_nx;
            conflict <= cmd_fwd & cmd_rev;
            if (timeout_set) begin
                rewind_timeout <= 1'b1;
            end else if (!remote_rewind && !sw1_rewind) begin
                rewind_timeout <= 1'b0;
            end
        end
    end

    assign motor_fwd     = (state == RUN_FWD);
    assign motor_rev     = (state == RUN_REV);
    assign wait_for_tape = (state == PULL_FWD) || (state == RUN_FWD) ||
                           (state == PULL_REV) || (state == RUN_REV);

endmodule

// File: doc/tape_motion_ctl.md
TAPE_MOTION_CTL -- requirements
Module: tape_motion_ctl

Interface
REQ-001 Parameter PULLIN_MS, default 5: relay pull-in time, in tick_ms pulses, before the motor output asserts; legal range 1..65535.
REQ-002 Parameter DEAD_MS, default 10: stop dead time, in tick_ms pulses, after any motor output drops; legal range 1..65535.
REQ-003 Parameter REWIND_MAX_MS, default 20000: maximum rewind run time in tick_ms pulses; legal range 1..65535.
REQ-004 clk  in  1  system clock (9.3 us period).
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 tick_ms  in  1  one-clk-wide pulse, once per ms, from timer.
REQ-007 cmd_fwd  in  1  computer forward request (PL6_PHOTO_TAPE_FWD).
REQ-008 cmd_rev  in  1  computer reverse request (PL6_PHOTO_TAPE_REV).
REQ-009 remote_rewind  in  1  typewriter-adapter rewind request (PL6_REMOTE_REWIND).
REQ-010 sw1_rewind  in  1  reader panel SWITCH_1 REWIND.
REQ-011 sw1_forward  in  1  reader panel SWITCH_1 FORWARD.
REQ-012 sw2  in  1  reader enable; 0 = all requests ignored.
REQ-013 motor_fwd  out  1  forward drive to tape_reader (RY-A).
REQ-014 motor_rev  out  1  reverse drive to tape_reader (RY-B).
REQ-015 wait_for_tape  out  1  PL6_WAIT_FOR_TAPE; relay energized.
REQ-016 owner  out  2  current source: 0 none, 1 computer, 2 panel fwd, 3 rewind.
REQ-017 rewind_timeout  out  1  sticky rewind-timeout flag.
REQ-018 conflict  out  1  one-clk pulse when cmd_fwd and cmd_rev are both high.

Function
REQ-019 States: IDLE, PULL_FWD, RUN_FWD, PULL_REV, RUN_REV, DEAD; all inputs sampled on rising clk.
REQ-020 Request arbitration, fixed priority: rewind (remote_rewind OR sw1_rewind, direction rev, owner 3) > sw1_forward (fwd, owner 2) > computer (cmd_fwd XOR cmd_rev, owner 1); cmd_fwd AND cmd_rev = no computer request, conflict pulses every clk it persists.
REQ-021 sw2=0 masks all requests: no winner.
REQ-022 IDLE + winner -> PULL_<dir> next edge, owner loaded, tick counter cleared.
REQ-023 16-bit tick counter cleared on every state entry, incremented only on tick_ms in PULL_*, RUN_REV (owner 3), DEAD; no wrap (parameters bound it).
REQ-024 PULL_<dir> -> RUN_<dir> on the edge where tick_ms=1 and count=PULLIN_MS-1 (exactly PULLIN_MS ticks after entry).
REQ-025 motor_fwd=1 only in RUN_FWD; motor_rev=1 only in RUN_REV; never both.
REQ-026 wait_for_tape=1 in PULL_* and RUN_*; 0 in IDLE and DEAD.
REQ-027 PULL_* or RUN_*: winner gone, or winner direction differs -> DEAD next edge; owner -> 0.
REQ-028 Winner same direction but different source: owner updates, state and counter unchanged (no restart of pull-in).
REQ-029 DEAD -> IDLE on the edge where tick_ms=1 and count=DEAD_MS-1; requests during DEAD are ignored until IDLE, then arbitrated normally.
REQ-030 RUN_REV with owner 3: on tick with count=REWIND_MAX_MS-1 -> DEAD, rewind_timeout set.
REQ-031 rewind_timeout stays set and blocks rewind-source requests (lower priority requests still served) until remote_rewind=0 and sw1_rewind=0 for one clk, then clears.
REQ-032 tick_ms coincident with a transition edge counts toward the state being left, not the new state.

Reset
REQ-033 rst=1 at a clk edge: state IDLE, counter 0, motor_fwd=0, motor_rev=0, wait_for_tape=0, owner=0, rewind_timeout=0, conflict=0; takes priority over all inputs, including mid-run.
REQ-034 First arbitration occurs on the first edge with rst=0.

Verification
REQ-035 rst released, cmd_fwd=1, sw2=1 -> wait_for_tape next clk, motor_fwd exactly 5 ticks later, owner=1; cmd_fwd=0 -> motor_fwd and wait_for_tape drop next clk, IDLE after 10 ticks.
REQ-036 RUN_FWD (computer), remote_rewind=1 -> DEAD 10 ticks, PULL_REV 5 ticks, motor_rev=1, owner=3.
REQ-037 RUN_FWD owner 1, sw1_forward=1 -> owner=2 next clk, motor_fwd never drops.
REQ-038 REWIND_MAX_MS=50, sw1_rewind held -> motor_rev 50 ticks, DEAD, rewind_timeout=1, no restart; sw1_rewind=0 one clk -> flag clears.
REQ-039 cmd_fwd=cmd_rev=1 -> conflict each clk, no motion; sw2=0 with sw1_forward=1 -> no motion.
REQ-040 rst=1 during RUN_REV -> all outputs 0 next clk, IDLE, no dead time.
